// File: rtl/izh_pkg.sv
// Shared types and saturation helpers for the Izhikevich neuron array.
// The optional refractory feature is enabled with the IZH_REFRACTORY_EN macro.
package izh_pkg;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

    // Saturation bounds of an n-bit two's-complement word
    function automatic logic signed [63:0] sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int n);
        if (x > sat_max(n))
            return sat_max(n);
        else if (x < sat_min(n))
            return sat_min(n);
        return x;
    endfunction

endpackage

// File: rtl/izh_neuron_step.sv
// Combinational single-neuron update: dv/dw derivatives, saturating adds and spike test.
// With IZH_REFRACTORY_EN a per-neuron refractory counter gates the update.
module scaled_calc_dv
    import izh_pkg::*;
#(
    parameter int N = 18,
    parameter int Q = 10
) (
    input  logic signed [N-1:0] v_i,
    input  logic signed [N-1:0] w_i,
    input  logic signed [N-1:0] cur_i,
    input  logic signed [N-1:0] step_i,
    output logic signed [N-1:0] dv_o
);
    logic signed [63:0] v, vv, raw, prod;

    // dv = step * (0.04 v^2 + 5 v + 140 - w + I), 0.04 ~= 41/1024
    always_comb begin
        v    = 64'(v_i);
        vv   = (v * v) >>> Q;
        raw  = ((vv * 64'sd41) >>> Q) + (64'sd5 * v) + (64'sd140 <<< Q) - 64'(w_i) + 64'(cur_i);
        prod = (raw * 64'(step_i)) >>> Q;
        dv_o = N'(sat(prod, N));
    end
endmodule

module calc_dw
    import izh_pkg::*;
#(
    parameter int N = 18,
    parameter int Q = 10
) (
    input  logic signed [N-1:0] v_i,
    input  logic signed [N-1:0] w_i,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    input  logic signed [N-1:0] step_i,
    output logic signed [N-1:0] dw_o
);
    logic signed [63:0] t, u, prod;

    // dw = step * a * (b v - w)
    always_comb begin
        t    = ((64'(b_i) * 64'(v_i)) >>> Q) - 64'(w_i);
        u    = (64'(a_i) * t) >>> Q;
        prod = (64'(step_i) * u) >>> Q;
        dw_o = N'(sat(prod, N));
    end
endmodule

module izh_neuron_step
    import izh_pkg::*;
#(
    parameter int N = 18,
    parameter int Q = 10
) (
    input  logic signed [N-1:0] v_i,
    input  logic signed [N-1:0] w_i,
    input  logic signed [N-1:0] cur_i,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    input  logic signed [N-1:0] c_i,
    input  logic signed [N-1:0] d_i,
    input  logic signed [N-1:0] v_th_i,
    input  logic signed [N-1:0] dv_step_i,
    input  logic signed [N-1:0] dw_step_i,
`ifdef IZH_REFRACTORY_EN
    input  logic [7:0]          ref_cnt_i,
    input  logic [7:0]          ref_period_i,
    output logic [7:0]          ref_cnt_o,
`endif
    output logic signed [N-1:0] v_o,
    output logic signed [N-1:0] w_o,
    output logic                spike_o
);
    logic signed [N-1:0] dv, dw;

    scaled_calc_dv #(.N(N), .Q(Q)) u_dv (
        .v_i(v_i), .w_i(w_i), .cur_i(cur_i), .step_i(dv_step_i), .dv_o(dv)
    );

    calc_dw #(.N(N), .Q(Q)) u_dw (
        .v_i(v_i), .w_i(w_i), .a_i(a_i), .b_i(b_i), .step_i(dw_step_i), .dw_o(dw)
    );

    always_comb begin
        spike_o = 1'b0;
        v_o     = N'(sat(64'(v_i) + 64'(dv), N));
        w_o     = N'(sat(64'(w_i) + 64'(dw), N));
`ifdef IZH_REFRACTORY_EN
        ref_cnt_o = ref_cnt_i;
        if (ref_cnt_i != 8'd0) begin
            v_o       = c_i;
            w_o       = w_i;
            ref_cnt_o = ref_cnt_i - 8'd1;
        end else if (v_i > v_th_i) begin
            v_o       = c_i;
            w_o       = N'(sat(64'(w_i) + 64'(d_i), N));
            spike_o   = 1'b1;
            ref_cnt_o = ref_period_i;
        end
`else
        if (v_i > v_th_i) begin
            v_o     = c_i;
            w_o     = N'(sat(64'(w_i) + 64'(d_i), N));
            spike_o = 1'b1;
        end
`endif
    end
endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron array: one shared step unit sweeps all neurons, one per cycle.
// IZH_REFRACTORY_EN adds a ref_period input and per-neuron refractory counters.
module izhikevich_array
    import izh_pkg::*;
#(
    parameter  int N           = 18,
    parameter  int Q           = 10,
    parameter  int NUM_NEURONS = 4,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_NEURONS*N-1:0]   i_bus,
    input  logic signed [N-1:0]        v_init,
    input  logic signed [N-1:0]        w_init,
    input  logic signed [N-1:0]        v_th,
    input  logic signed [N-1:0]        dv_step,
    input  logic signed [N-1:0]        dw_step,
    input  logic signed [N-1:0]        a,
    input  logic signed [N-1:0]        b,
    input  logic signed [N-1:0]        c,
    input  logic signed [N-1:0]        d,
`ifdef IZH_REFRACTORY_EN
    input  logic [7:0]                 ref_period,
`endif
    input  logic                       apply,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_NEURONS-1:0]     spikes,
    output logic signed [N-1:0]        rd_voltage,
    output logic signed [N-1:0]        rd_w
);
    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic signed [N-1:0]      v_q [NUM_NEURONS];
    logic signed [N-1:0]      w_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   spk_acc_q, spikes_q, spk_d;
    logic [NUM_NEURONS*N-1:0] ibus_q;
    logic signed [N-1:0]      a_q, b_q, c_q, d_q, vth_q, dvs_q, dws_q;
    logic                     busy_q, done_q;
    logic signed [N-1:0]      rd_v_q, rd_w_q;
    logic signed [N-1:0]      cur, v_nxt, w_nxt;
    logic                     spike, last;
`ifdef IZH_REFRACTORY_EN
    logic [7:0]               ref_q [NUM_NEURONS];
    logic [7:0]               ref_nxt;
`endif

    assign cur  = $signed(ibus_q[idx_q*N +: N]);
    assign last = (32'(idx_q) == NUM_NEURONS - 1);

    izh_neuron_step #(.N(N), .Q(Q)) u_step (
        .v_i(v_q[idx_q]), .w_i(w_q[idx_q]), .cur_i(cur),
        .a_i(a_q), .b_i(b_q), .c_i(c_q), .d_i(d_q), .v_th_i(vth_q),
        .dv_step_i(dvs_q), .dw_step_i(dws_q),
`ifdef IZH_REFRACTORY_EN
        .ref_cnt_i(ref_q[idx_q]), .ref_period_i(ref_period), .ref_cnt_o(ref_nxt),
`endif
        .v_o(v_nxt), .w_o(w_nxt), .spike_o(spike)
    );

    always_comb begin
        state_d = state_q;
        spk_d   = spk_acc_q;
        case (state_q)
            IDLE:  if (apply) state_d = SWEEP;
            SWEEP: begin
                spk_d[idx_q] = spike;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spikes_q  <= '0;
            spk_acc_q <= '0;
            rd_v_q    <= '0;
            rd_w_q    <= '0;
            ibus_q    <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            vth_q <= '0; dvs_q <= '0; dws_q <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_q[k] <= v_init;
                w_q[k] <= w_init;
`ifdef IZH_REFRACTORY_EN
                ref_q[k] <= 8'd0;
`endif
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            // Out-of-range select reads zero rather than an undefined element
            rd_v_q  <= (32'(rd_idx) < NUM_NEURONS) ? v_q[rd_idx] : '0;
            rd_w_q  <= (32'(rd_idx) < NUM_NEURONS) ? w_q[rd_idx] : '0;
            if (state_q == IDLE && apply) begin
                busy_q    <= 1'b1;
                idx_q     <= '0;
                spk_acc_q <= '0;
                ibus_q    <= i_bus;
                a_q <= a; b_q <= b; c_q <= c; d_q <= d;
                vth_q <= v_th; dvs_q <= dv_step; dws_q <= dw_step;
            end
            if (state_q == SWEEP) begin
                v_q[idx_q] <= v_nxt;
                w_q[idx_q] <= w_nxt;
`ifdef IZH_REFRACTORY_EN
                ref_q[idx_q] <= ref_nxt;
`endif
                spk_acc_q <= spk_d;
                idx_q     <= idx_q + 1'b1;
                if (last) begin
                    idx_q    <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    spikes_q <= spk_d;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign spikes     = spikes_q;
    assign rd_voltage = rd_v_q;
    assign rd_w       = rd_w_q;

endmodule

// File: doc/izhikevich_array.md
IZHIKEVICH_ARRAY -- requirements
Module: izhikevich_array

Interface
REQ-001 Parameter N, default 18, signed fixed-point word width.
REQ-002 Parameter Q, default 10, fractional bits of every fixed-point word.
REQ-003 Parameter NUM_NEURONS, default 4, neuron count, legal range 2..256.
REQ-004 Derived localparam IDX_W = $clog2(NUM_NEURONS), not overridable.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
REQ-006 Inputs, all N bits unless stated:
- i_bus  in  NUM_NEURONS*N  per-neuron input current; neuron k occupies bits [k*N +: N].
- v_init, w_init  reset values of every neuron's v and w.
- v_th  spike threshold.
- dv_step, dw_step  integration steps.
- a, b, c, d  Izhikevich constants, shared by all neurons.
- apply  in  1  start one update sweep.
- rd_idx  in  IDX_W  readback select.
REQ-007 Outputs:
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at the end of a sweep.
- spikes  out  NUM_NEURONS  spike vector from the last sweep.
- rd_voltage, rd_w  out  N  state of neuron rd_idx, registered.

Function
REQ-008 FSM states are IDLE and SWEEP; reset enters IDLE.
REQ-009 IDLE with apply=1 at an edge SHALL enter SWEEP with idx=0, busy=1, and latch i_bus, a, b, c, d, v_th, dv_step and dw_step for the whole sweep.
REQ-010 Each SWEEP edge SHALL update neuron idx and increment idx, so one neuron is processed per cycle.
REQ-011 Neuron update, spike case: if $signed(v) > $signed(v_th), then v<=c, w<=sat(w+d), spike bit idx<=1.
REQ-012 Neuron update, otherwise: v<=sat(v+dv), w<=sat(w+dw), spike bit idx<=0.
- dv and dw come from the team's scaled_calc_dv and calc_dw formulas.
REQ-013 sat() SHALL clamp a signed N+1-bit sum to the range [-2^(N-1), 2^(N-1)-1]; no wrap-around.
REQ-014 After the edge that updates neuron NUM_NEURONS-1, the FSM SHALL enter IDLE.
- At that same edge: busy<=0, done<=1 for exactly one cycle, and spikes<=the accumulated vector.
REQ-015 Latency: done SHALL be high in the cycle that follows apply edge + NUM_NEURONS edges.
REQ-016 apply while busy SHALL be ignored; apply in the cycle done is high SHALL start a new sweep.
REQ-017 spikes SHALL hold its value between done pulses.
REQ-018 rd_voltage and rd_w SHALL show the state of rd_idx as of the previous edge, one-cycle latency, valid in any state.
REQ-019 rd_idx >= NUM_NEURONS SHALL read zero.

Reset
REQ-020 rst SHALL override every other input, including mid-sweep.
REQ-021 Reset values: every neuron v=v_init and w=w_init, state=IDLE, idx=0, busy=0, done=0, spikes=0, rd_voltage=0, rd_w=0.
REQ-022 An apply sampled at a reset edge SHALL be discarded.

Configuration
REQ-023 Macro IZH_REFRACTORY_EN defined:
- Adds input ref_period (8 bits) and one 8-bit refractory counter per neuron, reset to 0.
- A spike loads the counter with ref_period.
- While the counter is nonzero, a neuron's sweep slot holds v=c and w unchanged, forces its spike bit to 0, and decrements the counter.
REQ-024 Macro IZH_REFRACTORY_EN undefined: the ref_period port and the counters SHALL be absent, and the behaviour SHALL be as in REQ-011 and REQ-012.

Structure
REQ-025 Package izh_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the saturation bound constants.
- The constants are functions of N.
REQ-026 Sub-module izh_neuron_step SHALL be purely combinational.
- It instantiates scaled_calc_dv, calc_dw and the saturating adds.
- It computes next v, next w and the spike bit for one neuron.
REQ-027 State storage SHALL be register arrays indexed by idx, one step instance shared by all neurons.

Verification
REQ-028 Reset: v_init=-70<<Q, w_init=0 -> every rd_voltage=-71680, rd_w=0, spikes=0, busy=0.
REQ-029 Latency: NUM_NEURONS=4, apply pulse at cycle 0 -> busy high in cycles 1-4, done high in cycle 5 only.
REQ-030 Spike: neuron 2 preset above v_th=30<<Q, with c=-65<<Q and d=8<<Q -> after the sweep:
- Neuron 2 has v=-66560 and w=w_old+8192.
- spikes=4'b0100.
REQ-031 Saturation: w=2^(N-1)-1 and d=1<<Q on a spike -> w stays 131071 for N=18.
REQ-032 Collisions: apply high in cycle 2 of a sweep is ignored; rst in cycle 2 yields IDLE, all state reset, no done pulse.
REQ-033 IZH_REFRACTORY_EN defined, ref_period=3 -> the spiking neuron holds v=c and spike bit 0 for the next 3 sweeps, then resumes normal updates.
